cfg_bus_sched: RTL and testbench

Round-robin scheduler that shares the narrow configuration bus of the `sub_module` datapath instances among several requesters (CPU shim, debug port, init sequencer). It accepts single-beat write or read transactions, drives the bus with explicit output-enable and turnaround cycles so no two agents ever drive it together, and returns one completion per accepted transaction. It sits between the requesters and the top-level tri-state `bidir_bus`. The top level resolves `bus_out`/`bus_oe`/`bus_in` onto the inout.

---
 rtl/cfg_bus_pkg.sv | 24 ++
 rtl/cfg_bus_sched_rr_pick.sv | 36 +++
 rtl/cfg_bus_sched.sv | 185 ++++++++++++++++++
 tb/tb_cfg_bus_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_bus_pkg.sv
// Shared types and constants for the configuration-bus scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Contents: scheduler state enum, op-code constants, small elaboration helper.
package cfg_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_TURN  = 3'd2,
      ST_RSTB  = 3'd3,
      ST_RWAIT = 3'd4,
      ST_RESP  = 3'd5
   } cfg_state_e;

   localparam logic CFG_OP_RD = 1'b0;
   localparam logic CFG_OP_WR = 1'b1;

   // Used to size the shared wait/turnaround counter.
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cfg_bus_sched_rr_pick.sv
// Combinational round-robin winner selection starting one past the last grant.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when the pick is used.
// Ports: req (request vector), last_gnt (previous winner index),
//        gnt_oh (one-hot winner), gnt_idx (winner index), gnt_any (some request present).
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_gnt,
   output logic [N_REQ-1:0] gnt_oh,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_any
);

   logic [IDX_W-1:0] cand;

   // Walk the requesters in priority order last_gnt+1, +2, ... wrapping;
   // the first one found asserted wins and later candidates are ignored.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'((int'(last_gnt) + k) % N_REQ);
         if (!gnt_any && req[cand]) begin
            gnt_any      = 1'b1;
            gnt_oh[cand] = 1'b1;
            gnt_idx      = cand;
         end
      end
   end

endmodule

// File: rtl/cfg_bus_sched.sv
// Round-robin scheduler sharing the narrow config bus among N_REQ requesters.
// Latency: write completes T+2+TURN_CYC, read T+2+RD_WAIT after accept at T.
// Backpressure: one transaction in flight; req_valid is only sampled in IDLE.
// Ports: req_valid/req_wr/req_wdata in, req_ready (one-hot accept) out;
//        rsp_valid (one-hot completion)/rsp_rdata out; bus_out/bus_oe/bus_stb/
//        bus_wr out to the tri-state bus and datapath, bus_in resolved bus value;
//        busy high whenever a transaction is in progress.
module cfg_bus_sched
   import cfg_bus_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int BUS_W    = 4,
   parameter int RD_WAIT  = 2,
   parameter int TURN_CYC = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_wr,
   input  logic [N_REQ*BUS_W-1:0]  req_wdata,
   output logic [N_REQ-1:0]        req_ready,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [BUS_W-1:0]        rsp_rdata,
   output logic [BUS_W-1:0]        bus_out,
   output logic                    bus_oe,
   input  logic [BUS_W-1:0]        bus_in,
   output logic                    bus_stb,
   output logic                    bus_wr,
   output logic                    busy
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(max2(RD_WAIT, TURN_CYC) + 1);

   cfg_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] gidx_q, gidx_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic             op_q, op_d;
   logic [BUS_W-1:0] wdat_q, wdat_d;
   logic [BUS_W-1:0] rdata_q, rdata_d;

   logic [BUS_W-1:0] bus_out_q, bus_out_d;
   logic             bus_oe_q, bus_oe_d;
   logic             bus_stb_q, bus_stb_d;
   logic             bus_wr_q, bus_wr_d;
   logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [BUS_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic             busy_q, busy_d;

   logic [N_REQ-1:0] pick_oh;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic [BUS_W-1:0] wdata_arr [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_wslice
      assign wdata_arr[i] = req_wdata[i*BUS_W +: BUS_W];
   end

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req      (req_valid),
      .last_gnt (last_q),
      .gnt_oh   (pick_oh),
      .gnt_idx  (pick_idx),
      .gnt_any  (pick_any)
   );

   // Accept is the only combinational output: a decode of IDLE and the pick.
   assign req_ready = (state_q == ST_IDLE) ? pick_oh : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      op_d    = op_q;
      wdat_d  = wdat_q;
      rdata_d = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               gidx_d  = pick_idx;
               last_d  = pick_idx;
               op_d    = req_wr[pick_idx];
               wdat_d  = wdata_arr[pick_idx];
               state_d = (req_wr[pick_idx] == CFG_OP_WR) ? ST_WRITE : ST_RSTB;
            end
         end
         ST_WRITE: begin
            state_d = ST_TURN;
            cnt_d   = CNT_W'(TURN_CYC - 1);
         end
         ST_TURN: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RSTB: begin
            state_d = ST_RWAIT;
            cnt_d   = CNT_W'(RD_WAIT - 1);
         end
         ST_RWAIT: begin
            // The datapath has had RD_WAIT cycles to settle; capture on the last.
            if (cnt_q == '0) begin
               rdata_d = bus_in;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      bus_oe_d    = (state_d == ST_WRITE);
      bus_out_d   = bus_oe_d ? wdat_d : '0;
      bus_stb_d   = (state_d == ST_WRITE) || (state_d == ST_RSTB);
      bus_wr_d    = (state_d == ST_WRITE);
      busy_d      = (state_d != ST_IDLE);
      rsp_valid_d = '0;
      rsp_rdata_d = '0;
      if (state_d == ST_RESP) begin
         rsp_valid_d[gidx_d] = 1'b1;
         if (op_d == CFG_OP_RD) begin
            rsp_rdata_d = rdata_d;
         end
      end
   end

   // Async reset clears bus_oe immediately, so an aborted write stops
   // driving the bus without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         gidx_q      <= '0;
         last_q      <= IDX_W'(N_REQ - 1);
         op_q        <= CFG_OP_RD;
         wdat_q      <= '0;
         rdata_q     <= '0;
         bus_out_q   <= '0;
         bus_oe_q    <= 1'b0;
         bus_stb_q   <= 1'b0;
         bus_wr_q    <= 1'b0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gidx_q      <= gidx_d;
         last_q      <= last_d;
         op_q        <= op_d;
         wdat_q      <= wdat_d;
         rdata_q     <= rdata_d;
         bus_out_q   <= bus_out_d;
         bus_oe_q    <= bus_oe_d;
         bus_stb_q   <= bus_stb_d;
         bus_wr_q    <= bus_wr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign bus_out   = bus_out_q;
   assign bus_oe    = bus_oe_q;
   assign bus_stb   = bus_stb_q;
   assign bus_wr    = bus_wr_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_cfg_bus_sched.sv
// Scoreboard bench for cfg_bus_sched: requesters, a one-register bus device,
// and a queue of expected completions checked by an independent monitor.
module tb_cfg_bus_sched;

   localparam int N   = 4;
   localparam int W   = 4;
   localparam int RDW = 2;
   localparam int TC  = 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid, req_wr, req_ready, rsp_valid;
   logic [N*W-1:0] req_wdata;
   logic [W-1:0]   rsp_rdata, bus_out, bus_in;
   logic           bus_oe, bus_stb, bus_wr, busy;

   always #5 clk = ~clk;

   cfg_bus_sched #(.N_REQ(N), .BUS_W(W), .RD_WAIT(RDW), .TURN_CYC(TC)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_wr(req_wr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
      .bus_stb(bus_stb), .bus_wr(bus_wr), .busy(busy)
   );

   typedef struct {
      int         idx;
      logic [W-1:0] rdata;
      int         due;
   } exp_t;

   exp_t sb_q[$];
   int   gnt_log[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;

   logic         v [N];
   logic         w [N];
   logic [W-1:0] d [N];
   bit           pending [N];
   bit           acc_prev [N];
   bit           rand_en = 0;
   bit           hold_all = 0;
   int           model_last = N - 1;
   logic [W-1:0] model_reg = 4'h3;
   logic [W-1:0] dev_reg = 4'h3;
   int           dev_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference arbitration: first valid requester after the previous winner.
   function automatic int rr_winner();
      for (int k = 1; k <= N; k++) begin
         int c = (model_last + k) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   function automatic bit any_v();
      for (int i = 0; i < N; i++) if (v[i]) return 1;
      return 0;
   endfunction

   function automatic bit any_pending();
      for (int i = 0; i < N; i++) if (pending[i]) return 1;
      return 0;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = v[i];
         req_wr[i]          = w[i];
         req_wdata[i*W +: W] = d[i];
      end
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) begin
         v[i] = 0; w[i] = 0; d[i] = '0; pending[i] = 0; acc_prev[i] = 0;
      end
      model_last = N - 1;
      drive_inputs();
   endtask

   // One cycle of requester behaviour; accepted transactions push expectations.
   task automatic step();
      bit rsp_now [N];
      bit idle;
      int win;
      exp_t e;
      @(negedge clk);
      idle = (rsp_valid == '0);
      for (int i = 0; i < N; i++) begin
         rsp_now[i] = rsp_valid[i];
         if (rsp_now[i]) pending[i] = 0;
         if (pending[i]) idle = 0;
      end
      for (int i = 0; i < N; i++) begin
         if (acc_prev[i]) begin v[i] = 0; acc_prev[i] = 0; end
         if (!v[i] && !pending[i] && !rsp_now[i] &&
             (hold_all || (rand_en && $urandom_range(0, 3) == 0))) begin
            v[i] = 1;
            w[i] = 1'($urandom_range(0, 1));
            d[i] = W'($urandom);
         end
      end
      drive_inputs();
      #1;
      chk("req_ready_onehot", 32'($onehot0(req_ready)), 1);
      chk("req_ready_when_idle", 32'(req_ready != '0), 32'(idle && any_v() && rst_n));
      if (req_ready != '0) begin
         win = rr_winner();
         if (win >= 0) begin
            chk("grant_winner", 32'(req_ready), 32'(1 << win));
            e.idx   = win;
            e.rdata = w[win] ? '0 : model_reg;
            e.due   = cyc + (w[win] ? 2 + TC : 2 + RDW);
            sb_q.push_back(e);
            gnt_log.push_back(win);
            if (w[win]) model_reg = d[win];
            model_last    = win;
            pending[win]  = 1;
            acc_prev[win] = 1;
         end
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 80; k++) begin
         if (sb_q.size() == 0 && !any_v() && !any_pending()) break;
         step();
      end
      chk("drain_queue_empty", 32'(sb_q.size()), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_reqs();
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Bus device: one register; writes capture bus_out, reads drive it back
   // from the strobe cycle through the sampling cycle.
   initial begin
      bus_in = '0;
      forever begin
         @(negedge clk);
         if (bus_oe) chk("bus_contention", 32'(dev_cnt), 0);
         if (bus_stb && bus_wr && bus_oe) dev_reg = bus_out;
         if (bus_stb && !bus_wr) dev_cnt = RDW + 1;
         else if (dev_cnt > 0) dev_cnt--;
         bus_in = (dev_cnt > 0) ? dev_reg : (bus_oe ? bus_out : '0);
      end
   end

   // Monitor: pops one expectation per completion and checks properties.
   initial begin
      exp_t e;
      logic prev_oe;
      prev_oe = 1'b0;
      forever begin
         @(negedge clk);
         if (rsp_valid != '0) begin
            chk("rsp_valid_onehot", 32'($onehot(rsp_valid)), 1);
            if (sb_q.size() == 0) begin
               chk("unexpected_rsp", 32'(rsp_valid), 0);
            end else begin
               e = sb_q.pop_front();
               chk("rsp_idx", 32'(rsp_valid), 32'(1 << e.idx));
               chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
               chk("rsp_cycle", 32'(cyc), 32'(e.due));
            end
         end
         if (bus_oe) begin
            chk("oe_needs_gap", 32'(prev_oe), 0);
            chk("oe_with_wr_strobe", 32'({bus_stb, bus_wr}), 32'b11);
         end
         prev_oe = bus_oe;
      end
   end

   initial begin
      int           t;
      int           exp_ord [5];
      logic [W-1:0] saved_reg;
      exp_ord = '{0, 1, 2, 3, 0};
      clear_reqs();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
      chk("rst_bus_out", 32'(bus_out), 0);
      chk("rst_bus_oe", 32'(bus_oe), 0);
      chk("rst_bus_stb", 32'(bus_stb), 0);
      chk("rst_bus_wr", 32'(bus_wr), 0);
      chk("rst_busy", 32'(busy), 0);
      #1 rst_n = 1'b1;

      // Write 0xA from requester 0.
      v[0] = 1; w[0] = 1; d[0] = 4'hA;
      step(); chk("wr_accept", 32'(req_ready), 32'b0001);
      step();
      chk("wr_oe", 32'(bus_oe), 1); chk("wr_stb", 32'(bus_stb), 1);
      chk("wr_wr", 32'(bus_wr), 1); chk("wr_data", 32'(bus_out), 32'hA);
      chk("wr_busy", 32'(busy), 1);
      step(); chk("turn_oe", 32'(bus_oe), 0); chk("turn_out", 32'(bus_out), 0);
      step(); chk("wr_rsp", 32'(rsp_valid), 32'b0001); chk("wr_rsp_rdata", 32'(rsp_rdata), 0);
      step(); chk("idle_busy", 32'(busy), 0);

      // Requester 1 writes 5, requester 2 reads it back.
      v[1] = 1; w[1] = 1; d[1] = 4'h5;
      repeat (5) step();
      v[2] = 1; w[2] = 0; d[2] = 4'h0;
      step(); chk("rd_accept", 32'(req_ready), 32'b0100);
      step(); chk("rd_stb", 32'({bus_stb, bus_wr, bus_oe}), 32'b100);
      step(); chk("rwait_oe", 32'(bus_oe), 0);
      step(); chk("rwait_oe2", 32'(bus_oe), 0);
      step(); chk("rd_rsp", 32'(rsp_valid), 32'b0100); chk("rd_rdata", 32'(rsp_rdata), 32'h5);
      step();

      // All requesters hold valid after reset: fair rotation from 0.
      do_reset();
      gnt_log.delete();
      hold_all = 1;
      repeat (24) step();
      hold_all = 0;
      drain();
      chk("rotation_count", 32'(gnt_log.size() >= 5), 1);
      for (int k = 0; k < 5; k++)
         if (k < gnt_log.size()) chk("rotation_order", 32'(gnt_log[k]), 32'(exp_ord[k]));

      // Requester 1 arrives during requester 3's turnaround.
      do_reset();
      v[3] = 1; w[3] = 1; d[3] = W'($urandom);
      step(); chk("r3_accept", 32'(req_ready), 32'b1000); t = cyc;
      step();
      v[1] = 1; w[1] = 0; d[1] = '0;
      step(); chk("no_accept_turn", 32'(req_ready), 0);
      step(); chk("no_accept_resp", 32'(req_ready), 0);
      step(); chk("r1_accept", 32'(req_ready), 32'b0010); chk("r1_accept_cycle", 32'(cyc - t), 4);
      drain();

      // Reset during the WRITE cycle aborts the transaction.
      do_reset();
      saved_reg = model_reg;
      v[0] = 1; w[0] = 1; d[0] = 4'h6;
      step(); chk("abort_accept", 32'(req_ready), 32'b0001);
      @(posedge clk); #1;
      chk("abort_oe_before", 32'(bus_oe), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_oe_async", 32'(bus_oe), 0);
      chk("abort_stb_async", 32'(bus_stb), 0);
      clear_reqs();
      sb_q.delete();
      model_reg = saved_reg;
      repeat (3) step();
      rst_n = 1'b1;
      v[0] = 1; w[0] = 0; v[2] = 1; w[2] = 1; d[2] = 4'h9;
      step(); chk("abort_prio0", 32'(req_ready), 32'b0001);
      drain();

      // Randomised traffic against the reference model.
      rand_en = 1;
      repeat (600) step();
      rand_en = 0;
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
